pfb_deadlock_report_scheduler: RTL and testbench
================================================

PFB_DEADLOCK_REPORT_SCHEDULER -- requirements
Module: pfb_deadlock_report_scheduler

Interface
REQ-001 Parameter NUM_MON, 8, number of per-process deadlock monitor inputs (2..32).
REQ-002 Parameter DEBOUNCE, 16, consecutive block cycles required to confirm a channel (1..255).
REQ-003 Derived constant IDX_W = clog2(NUM_MON).
REQ-004 Port clock  in  1  clock; all logic on rising edge.
REQ-005 Port reset  in  1  reset, synchronous, active-high.
REQ-006 Port mon_block  in  NUM_MON  per-process monitor block flags.
REQ-007 Port enable  in  1  scheduler enable.
REQ-008 Port clear  in  1  one-cycle pulse; clears sticky state.
REQ-009 Port rpt_valid  out  1  report offer valid.
REQ-010 Port rpt_ready  in  1  report sink ready.
REQ-011 Port rpt_idx  out  IDX_W  index of the reported channel.
REQ-012 Port rpt_count  out  8  reports completed since reset/clear, saturating.
REQ-013 Port deadlock  out  1  sticky: any channel confirmed.

Function
REQ-014 Each channel SHALL have a counter: +1 per cycle while mon_block[i]=1 and enable=1, saturating at DEBOUNCE; zeroed when mon_block[i]=0 or enable=0.
REQ-015 Confirmation of channel i SHALL occur only on the edge where its counter transitions DEBOUNCE-1 -> DEBOUNCE; a saturated counter SHALL NOT re-confirm.
REQ-016 Confirmation SHALL set pending[i] and deadlock on the same edge.
REQ-017 FSM states SHALL be IDLE, SCAN, OFFER; reset state IDLE.
REQ-018 IDLE -> SCAN when enable=1; SCAN -> IDLE when enable=0.
REQ-019 SCAN -> OFFER when any pending bit is set; rpt_idx SHALL be loaded with the round-robin winner, searching upward from rr_ptr with wrap at NUM_MON-1 -> 0.
REQ-020 In OFFER, rpt_valid=1 and rpt_idx SHALL stay stable until rpt_valid&rpt_ready; the offer SHALL never be withdrawn (enable, clear and new confirmations are ignored by the offer).
REQ-021 On handshake: clear pending[rpt_idx], rr_ptr = rpt_idx+1 (mod NUM_MON), rpt_count+1 saturating at 255, next state SCAN if enable=1 else IDLE.
REQ-022 Same-edge confirmation and handshake of the same index: set SHALL win (pending remains 1).
REQ-023 clear SHALL zero deadlock, all pending bits, rpt_count and rr_ptr; confirmations on the clear edge are dropped.
REQ-024 Latency: mon_block[i] sampled high on edges 1..DEBOUNCE with enable=1 and FSM in SCAN -> pending[i]/deadlock high after edge DEBOUNCE, rpt_valid high after edge DEBOUNCE+1.
REQ-025 Back-to-back: after a handshake, next offer SHALL appear no earlier than one SCAN cycle later (max one report per 2 cycles).

Reset
REQ-026 Reset SHALL force: FSM IDLE, rpt_valid=0, rpt_idx=0, rpt_count=0, deadlock=0, pending=0, rr_ptr=0, all counters 0, snap=0 (if present).
REQ-027 Reset mid-offer SHALL drop the offer on the next edge without a handshake.

Configuration
REQ-028 Macro PFB_DEADLOCK_SNAPSHOT_EN defined: output snap (NUM_MON bits) SHALL capture mon_block on the edge deadlock goes 0->1 and hold until reset/clear.
REQ-029 Macro undefined: snap port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package pfb_deadlock_pkg SHALL hold the FSM state enum, the clog2 function and rpt_count width constant (8).
REQ-031 Per-channel counter plus confirmation edge detect SHALL be a sub-module pfb_deadlock_debounce_ch, instantiated NUM_MON times via generate.

Verification (NUM_MON=4, DEBOUNCE=4)
REQ-032 mon_block=4'b0100 held from edge 1, enable=1, rpt_ready=1 -> deadlock high after edge 4, rpt_valid with rpt_idx=2 after edge 5, rpt_count=1 after edge 6, no second report.
REQ-033 mon_block[1] high 3 cycles, low 1, high 4 -> no confirmation after first burst; report idx=1 only after second burst.
REQ-034 Channels 0,1,3 confirmed same edge, rpt_ready=1 -> reports idx 0,1,3 in that order on alternate cycles; rr_ptr=0 after last.
REQ-035 rpt_ready=0 for 10 cycles during offer idx=3 while enable drops and clear pulses -> rpt_valid and rpt_idx=3 held; after handshake FSM IDLE, rpt_count=1 (clear preceded the handshake).
REQ-036 Reset asserted mid-OFFER -> rpt_valid=0, deadlock=0, rpt_count=0 next cycle; with PFB_DEADLOCK_SNAPSHOT_EN, snap=4'b1010 captured on first confirmation of 4'b1010 and cleared by reset.

Source files
------------

// File: rtl/pfb_deadlock_pkg.sv
// rtl/pfb_deadlock_pkg.sv - shared types and constants for the deadlock report scheduler
package pfb_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        OFFER = 2'd2
    } state_t;

    localparam int RPT_CNT_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pfb_deadlock_debounce_ch.sv
// rtl/pfb_deadlock_debounce_ch.sv - per-channel block debounce counter with confirmation pulse
module pfb_deadlock_debounce_ch #(
    parameter int DEBOUNCE = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic block,
    input  logic enable,
    output logic confirm
);

    logic [7:0] count;

    // Fires only on the DEBOUNCE-1 -> DEBOUNCE step, so a saturated counter stays quiet.
    assign confirm = block && enable && (count == 8'(DEBOUNCE - 1));

    always_ff @(posedge clock) begin
        if (reset || !block || !enable) begin
            count <= '0;
        end else if (count != 8'(DEBOUNCE)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/pfb_deadlock_report_scheduler.sv
// rtl/pfb_deadlock_report_scheduler.sv - round-robin deadlock report scheduler; PFB_DEADLOCK_SNAPSHOT_EN adds snap
module pfb_deadlock_report_scheduler
    import pfb_deadlock_pkg::*;
#(
    parameter int NUM_MON  = 8,
    parameter int DEBOUNCE = 16,
    localparam int IDX_W   = clog2(NUM_MON)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_MON-1:0]   mon_block,
    input  logic                 enable,
    input  logic                 clear,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [IDX_W-1:0]     rpt_idx,
    output logic [RPT_CNT_W-1:0] rpt_count,
    output logic                 deadlock
`ifdef PFB_DEADLOCK_SNAPSHOT_EN
    ,
    output logic [NUM_MON-1:0]   snap
`endif
);

    state_t               state;
    state_t               state_next;
    logic [NUM_MON-1:0]   pending;
    logic [NUM_MON-1:0]   confirm;
    logic [NUM_MON-1:0]   hs_mask;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     next_ptr;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     scan_idx;
    logic                 win_found;
    logic                 handshake;

    for (genvar i = 0; i < NUM_MON; i++) begin : g_ch
        pfb_deadlock_debounce_ch #(
            .DEBOUNCE(DEBOUNCE)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .block   (mon_block[i]),
            .enable  (enable),
            .confirm (confirm[i])
        );
    end

    assign rpt_valid = (state == OFFER);
    assign handshake = rpt_valid && rpt_ready;
    assign hs_mask   = handshake ? (NUM_MON'(1) << rpt_idx) : '0;
    assign next_ptr  = (rpt_idx == IDX_W'(NUM_MON - 1)) ? '0 : rpt_idx + IDX_W'(1);

    // Round-robin search upward from rr_ptr, wrapping at the last channel.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = rr_ptr;
        for (int k = 0; k < NUM_MON; k++) begin
            if (!win_found && pending[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = (scan_idx == IDX_W'(NUM_MON - 1)) ? '0 : scan_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // An offer, once made, only ends on a handshake (or reset).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = SCAN;
            SCAN:    begin
                if (!enable)                  state_next = IDLE;
                else if (win_found && !clear) state_next = OFFER;
            end
            OFFER:   if (rpt_ready) state_next = enable ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_idx   <= '0;
            rpt_count <= '0;
            rr_ptr    <= '0;
            pending   <= '0;
            deadlock  <= 1'b0;
        end else begin
            if (state == SCAN && state_next == OFFER) rpt_idx <= win_idx;
            if (clear) begin
                rpt_count <= '0;
                rr_ptr    <= '0;
                pending   <= '0;
                deadlock  <= 1'b0;
            end else begin
                if (handshake) begin
                    rr_ptr <= next_ptr;
                    if (rpt_count != '1) rpt_count <= rpt_count + 1'b1;
                end
                // A confirmation landing on the handshake edge keeps its pending bit.
                pending  <= (pending & ~hs_mask) | confirm;
                deadlock <= deadlock | (|confirm);
            end
        end
    end

`ifdef PFB_DEADLOCK_SNAPSHOT_EN
    always_ff @(posedge clock) begin
        if (reset || clear)               snap <= '0;
        else if (!deadlock && |confirm)   snap <= mon_block;
    end
`endif

endmodule

// File: tb/tb_pfb_deadlock_report_scheduler.sv
// tb/tb_pfb_deadlock_report_scheduler.sv - scoreboard bench for the deadlock report scheduler
module tb_pfb_deadlock_report_scheduler;
    import pfb_deadlock_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] mon_block;
    logic       enable;
    logic       clear;
    logic       rpt_valid;
    logic       rpt_ready;
    logic [1:0] rpt_idx;
    logic [7:0] rpt_count;
    logic       deadlock;
`ifdef PFB_DEADLOCK_SNAPSHOT_EN
    logic [3:0] snap;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    pfb_deadlock_report_scheduler #(
        .NUM_MON  (4),
        .DEBOUNCE (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mon_block (mon_block),
        .enable    (enable),
        .clear     (clear),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_idx   (rpt_idx),
        .rpt_count (rpt_count),
        .deadlock  (deadlock)
`ifdef PFB_DEADLOCK_SNAPSHOT_EN
        ,
        .snap      (snap)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks offer stability.
    initial begin
        logic       prev_hold;
        logic [1:0] prev_idx;
        int         e;
        prev_hold = 1'b0;
        prev_idx  = '0;
        forever begin
            @(negedge clock);
            if (prev_hold) begin
                check("hold_valid", int'(rpt_valid), 1);
                check("hold_idx", int'(rpt_idx), int'(prev_idx));
            end
            if (rpt_valid && rpt_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_report actual idx %0d expected none", rpt_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("report_idx", int'(rpt_idx), e);
                end
            end
            prev_hold = rpt_valid && !rpt_ready && !reset;
            prev_idx  = rpt_idx;
        end
    end

    initial begin
        reset = 1'b1; mon_block = '0; enable = 1'b0; clear = 1'b0; rpt_ready = 1'b0;
        step(2);
        reset = 1'b0;
        check("rst_valid", int'(rpt_valid), 0);
        check("rst_idx", int'(rpt_idx), 0);
        check("rst_count", int'(rpt_count), 0);
        check("rst_deadlock", int'(deadlock), 0);

        // Single channel 2 confirmation and report
        enable = 1'b1; rpt_ready = 1'b1;
        step(1);
        mon_block = 4'b0100;
        exp_q.push_back(2);
        step(3);
        check("t1_deadlock_e3", int'(deadlock), 0);
        step(1);
        check("t1_deadlock_e4", int'(deadlock), 1);
        check("t1_valid_e4", int'(rpt_valid), 0);
        step(1);
        check("t1_valid_e5", int'(rpt_valid), 1);
        check("t1_idx_e5", int'(rpt_idx), 2);
        step(1);
        check("t1_count_e6", int'(rpt_count), 1);
        step(8);
        check("t1_count_late", int'(rpt_count), 1);
        check("t1_valid_late", int'(rpt_valid), 0);
        mon_block = '0;

        // Broken burst on channel 1 must not confirm
        clear = 1'b1; step(1); clear = 1'b0;
        check("t2_clear_deadlock", int'(deadlock), 0);
        check("t2_clear_count", int'(rpt_count), 0);
        mon_block = 4'b0010; step(3);
        mon_block = 4'b0000; step(1);
        check("t2_no_confirm", int'(deadlock), 0);
        mon_block = 4'b0010;
        exp_q.push_back(1);
        step(4);
        check("t2_deadlock", int'(deadlock), 1);
        step(1);
        check("t2_idx", int'(rpt_idx), 1);
        step(1);
        check("t2_count", int'(rpt_count), 1);
        mon_block = '0;

        // Channels 0,1,3 confirmed together, round-robin order
        clear = 1'b1; step(1); clear = 1'b0;
        mon_block = 4'b1011;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        step(5);
        check("t3_idx0", int'(rpt_idx), 0);
        check("t3_valid0", int'(rpt_valid), 1);
        step(1);
        check("t3_gap0", int'(rpt_valid), 0);
        step(1);
        check("t3_idx1", int'(rpt_idx), 1);
        step(1);
        check("t3_gap1", int'(rpt_valid), 0);
        step(1);
        check("t3_idx3", int'(rpt_idx), 3);
        step(1);
        check("t3_count", int'(rpt_count), 3);
        check("t3_rr_ptr", int'(dut.rr_ptr), 0);
        mon_block = '0;
        step(1);

        // Offer held through enable drop and clear
        rpt_ready = 1'b0;
        mon_block = 4'b1000;
        exp_q.push_back(3);
        step(5);
        check("t4_valid", int'(rpt_valid), 1);
        check("t4_idx", int'(rpt_idx), 3);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) enable = 1'b0;
            clear = (i == 4);
            step(1);
            check("t4_hold_valid", int'(rpt_valid), 1);
            check("t4_hold_idx", int'(rpt_idx), 3);
        end
        clear = 1'b0;
        rpt_ready = 1'b1;
        step(1);
        check("t4_valid_after", int'(rpt_valid), 0);
        check("t4_count", int'(rpt_count), 1);
        check("t4_state_idle", int'(dut.state), int'(IDLE));
        mon_block = '0;

        // Reset during an offer
        rpt_ready = 1'b0; enable = 1'b1;
        step(1);
        mon_block = 4'b1010;
        step(4);
        check("t5_deadlock", int'(deadlock), 1);
`ifdef PFB_DEADLOCK_SNAPSHOT_EN
        check("t5_snap", int'(snap), 10);
`endif
        step(1);
        check("t5_valid", int'(rpt_valid), 1);
        check("t5_idx", int'(rpt_idx), 1);
        reset = 1'b1;
        step(1);
        check("t5_rst_valid", int'(rpt_valid), 0);
        check("t5_rst_deadlock", int'(deadlock), 0);
        check("t5_rst_count", int'(rpt_count), 0);
`ifdef PFB_DEADLOCK_SNAPSHOT_EN
        check("t5_rst_snap", int'(snap), 0);
`endif
        reset = 1'b0; mon_block = '0;
        step(3);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
